// File: rtl/pc_branch_if.sv
// Fetch-side bundle for the program-counter/branch unit: control, table
// programming and PC/status outputs.
interface pc_branch_if #(
    parameter int D  = 12,
    parameter int N  = 16,
    localparam int IW = $clog2(N)
);
    logic          start;
    logic [D-1:0]  start_addr;
    logic          stall;
    logic          branch;
    logic          halt_req;
    logic          tbl_we;
    logic          tbl_clr;
    logic [IW-1:0] tbl_idx;
    logic [D-1:0]  tbl_pc;
    logic [D-1:0]  tbl_off;
    logic          tbl_abs;
    logic [D-1:0]  pc;
    logic          running;
    logic          halted;
    logic          hit;
    logic          miss_err;

    modport master (
        output start, start_addr, stall, branch, halt_req,
               tbl_we, tbl_clr, tbl_idx, tbl_pc, tbl_off, tbl_abs,
        input  pc, running, halted, hit, miss_err
    );

    modport slave (
        input  start, start_addr, stall, branch, halt_req,
               tbl_we, tbl_clr, tbl_idx, tbl_pc, tbl_off, tbl_abs,
        output pc, running, halted, hit, miss_err
    );
endinterface

// File: rtl/pc_branch_unit.sv
// Program counter with run/halt control and an associative branch-target
// table searched on taken branches (lowest matching valid index wins).
module pc_branch_unit #(
    parameter int D  = 12,
    parameter int N  = 16,
    localparam int IW = $clog2(N)
) (
    input  logic        clk,
    input  logic        reset,
    pc_branch_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

    state_t        state_q, state_nxt;
    logic [D-1:0]  pc_q, pc_nxt;
    logic          hit_q, hit_nxt;
    logic          miss_q, miss_set;
    logic [N-1:0]  valid_q;

    logic [D-1:0]  tag_mem [N];
    logic [D-1:0]  off_mem [N];
    logic          abs_mem [N];

    logic          match_found;
    logic [IW-1:0] match_idx;
    logic [D-1:0]  target;

    // Parallel tag compare; scanning downwards leaves the lowest match last.
    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (valid_q[i] && tag_mem[i] == pc_q) begin
                match_found = 1'b1;
                match_idx   = IW'(i);
            end
        end
    end

    assign target = abs_mem[match_idx] ? off_mem[match_idx]
                                       : pc_q + off_mem[match_idx];

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state_q;
        pc_nxt    = pc_q;
        hit_nxt   = 1'b0;
        miss_set  = 1'b0;
        unique case (state_q)
            S_IDLE, S_HALT: begin
                if (bus.start) begin
                    pc_nxt    = bus.start_addr;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.halt_req) begin
                    state_nxt = S_HALT;
                end else if (bus.stall) begin
                    pc_nxt = pc_q;
                end else if (bus.branch) begin
                    if (match_found) begin
                        pc_nxt  = target;
                        hit_nxt = 1'b1;
                    end else begin
                        pc_nxt   = pc_q + 1'b1;
                        miss_set = 1'b1;
                    end
                end else begin
                    pc_nxt = pc_q + 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            valid_q <= '0;
        end else begin
            state_q <= state_nxt;
            pc_q    <= pc_nxt;
            hit_q   <= hit_nxt;
            if (bus.tbl_clr)
                miss_q <= 1'b0;
            else if (miss_set)
                miss_q <= 1'b1;
            // Later bit write overrides the clear, so a same-cycle write ends valid.
            if (bus.tbl_clr)
                valid_q <= '0;
            if (bus.tbl_we)
                valid_q[bus.tbl_idx] <= 1'b1;
        end
    end

    // NOTE: tag/offset storage has no reset; the valid bits alone gate every lookup.
    always_ff @(posedge clk) begin
        if (bus.tbl_we) begin
            tag_mem[bus.tbl_idx] <= bus.tbl_pc;
            off_mem[bus.tbl_idx] <= bus.tbl_off;
            abs_mem[bus.tbl_idx] <= bus.tbl_abs;
        end
    end

    assign bus.pc       = pc_q;
    assign bus.running  = (state_q == S_RUN);
    assign bus.halted   = (state_q == S_HALT);
    assign bus.hit      = hit_q;
    assign bus.miss_err = miss_q;
endmodule

// File: tb/tb_pc_branch_unit.sv
// Self-checking bench for pc_branch_unit: directed scenarios plus a random
// run, all compared against a behavioural model of the fetch rules.
module tb_pc_branch_unit;
    localparam int D   = 12;
    localparam int N   = 16;
    localparam int MOD = 1 << D;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pc_branch_if #(.D(D), .N(N)) bus ();
    pc_branch_unit #(.D(D), .N(N)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model
    int m_pc;
    bit m_run, m_halt, m_hit, m_miss;
    int m_tag [N];
    int m_off [N];
    bit m_abs [N];
    bit m_valid [N];

    task automatic clear_inputs();
        reset = 1'b0;
        bus.start = 1'b0; bus.start_addr = '0; bus.stall = 1'b0;
        bus.branch = 1'b0; bus.halt_req = 1'b0; bus.tbl_we = 1'b0;
        bus.tbl_clr = 1'b0; bus.tbl_idx = '0; bus.tbl_pc = '0;
        bus.tbl_off = '0; bus.tbl_abs = 1'b0;
    endtask

    // Advance the model with the inputs currently applied, then clock the DUT.
    task automatic tick();
        int np, idx;
        bit nhit, mset;
        if (reset) begin
            m_pc = 0; m_run = 0; m_halt = 0; m_hit = 0; m_miss = 0;
            for (int i = 0; i < N; i++) m_valid[i] = 0;
        end else begin
            np = m_pc; nhit = 0; mset = 0;
            if (!m_run) begin
                if (bus.start) begin
                    np = int'(bus.start_addr); m_run = 1; m_halt = 0;
                end
            end else if (bus.halt_req) begin
                m_run = 0; m_halt = 1;
            end else if (bus.stall) begin
                np = m_pc;
            end else if (bus.branch) begin
                idx = -1;
                for (int i = 0; i < N; i++)
                    if (idx < 0 && m_valid[i] && m_tag[i] == m_pc) idx = i;
                if (idx >= 0) begin
                    np = m_abs[idx] ? m_off[idx] : (m_pc + m_off[idx]) % MOD;
                    nhit = 1;
                end else begin
                    np = (m_pc + 1) % MOD;
                    mset = 1;
                end
            end else begin
                np = (m_pc + 1) % MOD;
            end
            if (bus.tbl_clr)
                for (int i = 0; i < N; i++) m_valid[i] = 0;
            if (bus.tbl_we) begin
                m_tag[bus.tbl_idx]   = int'(bus.tbl_pc);
                m_off[bus.tbl_idx]   = int'(bus.tbl_off);
                m_abs[bus.tbl_idx]   = bus.tbl_abs;
                m_valid[bus.tbl_idx] = 1;
            end
            if (bus.tbl_clr) m_miss = 0;
            else if (mset) m_miss = 1;
            m_pc = np; m_hit = nhit;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic restart(input int addr);
        bus.halt_req = 1'b1; tick(); bus.halt_req = 1'b0;
        bus.start = 1'b1; bus.start_addr = D'(addr); tick();
        bus.start = 1'b0;
    endtask

    task automatic write_entry(input int idx, input int tag, input int off, input bit abs_t);
        bus.tbl_we = 1'b1; bus.tbl_idx = 4'(idx); bus.tbl_pc = D'(tag);
        bus.tbl_off = D'(off); bus.tbl_abs = abs_t;
        tick();
        bus.tbl_we = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; tick(); reset = 1'b0;
        n_checks++;
        if (bus.pc !== 12'h000 || bus.running !== 1'b0 || bus.halted !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: pc=%h run=%b halt=%b expected pc=000 run=0 halt=0",
                     bus.pc, bus.running, bus.halted);
        end
        n_checks++;
        if (bus.hit !== 1'b0 || bus.miss_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: hit=%b miss=%b expected 0 0", bus.hit, bus.miss_err);
        end
    endtask

    task automatic test_increment();
        bus.start = 1'b1; bus.start_addr = 12'h010; tick(); bus.start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (bus.pc !== D'(16 + k) || bus.running !== 1'b1 || bus.hit !== 1'b0) begin
                n_fail++;
                $display("FAIL increment[%0d]: pc=%h run=%b hit=%b expected pc=%h run=1 hit=0",
                         k, bus.pc, bus.running, bus.hit, 16 + k);
            end
            if (k < 3) tick();
        end
    endtask

    task automatic test_relative();
        write_entry(3, 'h004, 'hFFF, 1'b0);
        restart('h004);
        bus.branch = 1'b1; tick(); bus.branch = 1'b0;
        n_checks++;
        if (bus.pc !== 12'h003 || bus.hit !== 1'b1) begin
            n_fail++;
            $display("FAIL rel_branch: pc=%h hit=%b expected pc=003 hit=1", bus.pc, bus.hit);
        end
        write_entry(1, 'h004, 'h014, 1'b0);
        restart('h004);
        bus.branch = 1'b1; tick(); bus.branch = 1'b0;
        n_checks++;
        if (bus.pc !== 12'h018 || bus.hit !== 1'b1) begin
            n_fail++;
            $display("FAIL lowest_index: pc=%h hit=%b expected pc=018 hit=1", bus.pc, bus.hit);
        end
    endtask

    task automatic test_absolute_wrap();
        write_entry(0, 'h020, 'h100, 1'b1);
        restart('h020);
        bus.branch = 1'b1; tick(); bus.branch = 1'b0;
        n_checks++;
        if (bus.pc !== 12'h100 || bus.hit !== 1'b1) begin
            n_fail++;
            $display("FAIL abs_branch: pc=%h hit=%b expected pc=100 hit=1", bus.pc, bus.hit);
        end
        restart('hFFF);
        tick();
        n_checks++;
        if (bus.pc !== 12'h000) begin
            n_fail++;
            $display("FAIL inc_wrap: pc=%h expected 000", bus.pc);
        end
        write_entry(5, 'hFFE, 'h005, 1'b0);
        restart('hFFE);
        bus.branch = 1'b1; tick(); bus.branch = 1'b0;
        n_checks++;
        if (bus.pc !== 12'h003 || bus.hit !== 1'b1) begin
            n_fail++;
            $display("FAIL rel_wrap: pc=%h hit=%b expected pc=003 hit=1", bus.pc, bus.hit);
        end
    endtask

    task automatic test_miss_clear();
        restart('h030);
        bus.branch = 1'b1; tick(); bus.branch = 1'b0;
        n_checks++;
        if (bus.pc !== 12'h031 || bus.hit !== 1'b0 || bus.miss_err !== 1'b1) begin
            n_fail++;
            $display("FAIL miss: pc=%h hit=%b miss=%b expected pc=031 hit=0 miss=1",
                     bus.pc, bus.hit, bus.miss_err);
        end
        tick(); tick();
        n_checks++;
        if (bus.miss_err !== 1'b1) begin
            n_fail++;
            $display("FAIL miss_sticky: miss=%b expected 1", bus.miss_err);
        end
        bus.tbl_clr = 1'b1; tick(); bus.tbl_clr = 1'b0;
        n_checks++;
        if (bus.miss_err !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_miss: miss=%b expected 0", bus.miss_err);
        end
        restart('h004);
        bus.branch = 1'b1; tick(); bus.branch = 1'b0;
        n_checks++;
        if (bus.pc !== 12'h005 || bus.hit !== 1'b0 || bus.miss_err !== 1'b1) begin
            n_fail++;
            $display("FAIL cleared_entry: pc=%h hit=%b miss=%b expected pc=005 hit=0 miss=1",
                     bus.pc, bus.hit, bus.miss_err);
        end
        // Miss concurrent with clear: clear wins. Clear+write: entry survives.
        restart('h060);
        bus.branch = 1'b1; bus.tbl_clr = 1'b1;
        bus.tbl_we = 1'b1; bus.tbl_idx = 4'd7; bus.tbl_pc = 12'h061;
        bus.tbl_off = 12'h300; bus.tbl_abs = 1'b1;
        tick();
        bus.tbl_clr = 1'b0; bus.tbl_we = 1'b0;
        n_checks++;
        if (bus.pc !== 12'h061 || bus.miss_err !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_vs_miss: pc=%h miss=%b expected pc=061 miss=0", bus.pc, bus.miss_err);
        end
        tick(); bus.branch = 1'b0;
        n_checks++;
        if (bus.pc !== 12'h300 || bus.hit !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_and_we: pc=%h hit=%b expected pc=300 hit=1", bus.pc, bus.hit);
        end
    endtask

    task automatic test_priority();
        restart('h0A0);
        bus.halt_req = 1'b1; bus.stall = 1'b1; bus.branch = 1'b1; tick();
        bus.halt_req = 1'b0; bus.stall = 1'b0; bus.branch = 1'b0;
        n_checks++;
        if (bus.pc !== 12'h0A0 || bus.halted !== 1'b1 || bus.running !== 1'b0 || bus.hit !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_prio: pc=%h halt=%b run=%b hit=%b expected pc=0a0 halt=1 run=0 hit=0",
                     bus.pc, bus.halted, bus.running, bus.hit);
        end
        bus.branch = 1'b1; tick(); bus.branch = 1'b0;
        n_checks++;
        if (bus.pc !== 12'h0A0 || bus.miss_err !== 1'b0) begin
            n_fail++;
            $display("FAIL branch_in_halt: pc=%h miss=%b expected pc=0a0 miss=0", bus.pc, bus.miss_err);
        end
        bus.start = 1'b1; bus.start_addr = 12'h200; tick(); bus.start = 1'b0;
        n_checks++;
        if (bus.pc !== 12'h200 || bus.running !== 1'b1 || bus.halted !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_restart: pc=%h run=%b halt=%b expected pc=200 run=1 halt=0",
                     bus.pc, bus.running, bus.halted);
        end
        write_entry(4, 'h201, 'h010, 1'b0);
        bus.stall = 1'b1; bus.branch = 1'b1; tick(); bus.stall = 1'b0;
        n_checks++;
        if (bus.pc !== 12'h201 || bus.hit !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_prio: pc=%h hit=%b expected pc=201 hit=0", bus.pc, bus.hit);
        end
        tick(); bus.branch = 1'b0;
        n_checks++;
        if (bus.pc !== 12'h211 || bus.hit !== 1'b1) begin
            n_fail++;
            $display("FAIL after_stall: pc=%h hit=%b expected pc=211 hit=1", bus.pc, bus.hit);
        end
        bus.start = 1'b1; bus.start_addr = 12'h555; tick(); bus.start = 1'b0;
        n_checks++;
        if (bus.pc !== 12'h212) begin
            n_fail++;
            $display("FAIL start_in_run: pc=%h expected 212", bus.pc);
        end
    endtask

    task automatic test_collision_reset();
        bus.tbl_clr = 1'b1; tick(); bus.tbl_clr = 1'b0;
        restart('h040);
        bus.branch = 1'b1; bus.tbl_we = 1'b1; bus.tbl_idx = 4'd2;
        bus.tbl_pc = 12'h040; bus.tbl_off = 12'h002; bus.tbl_abs = 1'b0;
        tick();
        bus.branch = 1'b0; bus.tbl_we = 1'b0;
        n_checks++;
        if (bus.pc !== 12'h041 || bus.hit !== 1'b0 || bus.miss_err !== 1'b1) begin
            n_fail++;
            $display("FAIL write_collision: pc=%h hit=%b miss=%b expected pc=041 hit=0 miss=1",
                     bus.pc, bus.hit, bus.miss_err);
        end
        reset = 1'b1; tick(); reset = 1'b0;
        n_checks++;
        if (bus.pc !== 12'h000 || bus.running !== 1'b0 || bus.miss_err !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_run_reset: pc=%h run=%b miss=%b expected pc=000 run=0 miss=0",
                     bus.pc, bus.running, bus.miss_err);
        end
        bus.start = 1'b1; bus.start_addr = 12'h040; tick(); bus.start = 1'b0;
        bus.branch = 1'b1; tick(); bus.branch = 1'b0;
        n_checks++;
        if (bus.pc !== 12'h041 || bus.hit !== 1'b0 || bus.miss_err !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_invalidates: pc=%h hit=%b miss=%b expected pc=041 hit=0 miss=1",
                     bus.pc, bus.hit, bus.miss_err);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            reset         = ($urandom_range(0, 99) == 0);
            bus.start     = ($urandom_range(0, 7) == 0);
            bus.start_addr = D'($urandom);
            bus.stall     = ($urandom_range(0, 5) == 0);
            bus.branch    = ($urandom_range(0, 1) == 0);
            bus.halt_req  = ($urandom_range(0, 19) == 0);
            bus.tbl_we    = ($urandom_range(0, 3) == 0);
            bus.tbl_clr   = ($urandom_range(0, 29) == 0);
            bus.tbl_idx   = 4'($urandom);
            bus.tbl_pc    = $urandom_range(0, 1) ? D'(m_pc + $urandom_range(0, 3)) : D'($urandom);
            bus.tbl_off   = D'($urandom);
            bus.tbl_abs   = 1'($urandom);
            tick();
            n_checks++;
            if (bus.pc !== D'(m_pc) || bus.hit !== m_hit || bus.miss_err !== m_miss ||
                bus.running !== m_run || bus.halted !== m_halt) begin
                n_fail++;
                $display("FAIL random[%0d]: pc=%h hit=%b miss=%b run=%b halt=%b expected pc=%h hit=%b miss=%b run=%b halt=%b",
                         c, bus.pc, bus.hit, bus.miss_err, bus.running, bus.halted,
                         D'(m_pc), m_hit, m_miss, m_run, m_halt);
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        m_pc = 0; m_run = 0; m_halt = 0; m_hit = 0; m_miss = 0;
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_off[i] = 0; m_abs[i] = 0;
        end
        #1;
        test_reset();
        test_increment();
        test_relative();
        test_absolute_wrap();
        test_miss_clear();
        test_priority();
        test_collision_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
